// File: rtl/lcd_win_pkg.sv
// Shared constants, FSM state type and origin helper for lcd_win_ctrl.
// Optional feature macro: LCD_WIN_MIRROR_EN.
package lcd_win_pkg;

    localparam logic [2:0] CMD_REFLASH = 3'd0;
    localparam logic [2:0] CMD_LOAD    = 3'd1;
    localparam logic [2:0] CMD_RIGHT   = 3'd2;
    localparam logic [2:0] CMD_LEFT    = 3'd3;
    localparam logic [2:0] CMD_UP      = 3'd4;
    localparam logic [2:0] CMD_DOWN    = 3'd5;
    localparam logic [2:0] CMD_MIRROR  = 3'd6;
    localparam logic [2:0] CMD_CLEAR   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_OUT
    } state_t;

    function automatic int default_origin(input int img, input int win);
        return (img - win + 1) / 2;
    endfunction

endpackage

// File: rtl/lcd_win_addr_gen.sv
// Window beat counter and mirror-aware pixel address generator.
// Mirror input is tied low unless LCD_WIN_MIRROR_EN is defined.
module lcd_win_addr_gen
    import lcd_win_pkg::*;
#(
    parameter int IMG_W = 6,
    parameter int WIN_W = 3,
    parameter int WIN_H = 3,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          mirror,
    input  logic [AW-1:0] x,
    input  logic [AW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int CW = $clog2(WIN_W + 1);
    localparam int RW = $clog2(WIN_H + 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;
    logic [AW-1:0] col_off;
    logic [AW-1:0] row_base;

    assign col_end  = (col == CW'(WIN_W - 1));
    assign last     = col_end && (row == RW'(WIN_H - 1));
    assign col_off  = mirror ? AW'(WIN_W - 1) - AW'(col) : AW'(col);
    assign row_base = (y + AW'(row)) * AW'(IMG_W);
    assign addr     = row_base + x + col_off;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_win_ctrl.sv
// Window-scan LCD controller: pixel store, origin registers and command FSM.
// Define LCD_WIN_MIRROR_EN to enable the horizontal-mirror command.
module lcd_win_ctrl
    import lcd_win_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int WIN_W = 3,
    parameter int WIN_H = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] X0   = AW'(default_origin(IMG_W, WIN_W));
    localparam logic [AW-1:0] Y0   = AW'(default_origin(IMG_H, WIN_H));
    localparam logic [AW-1:0] XMAX = AW'(IMG_W - WIN_W);
    localparam logic [AW-1:0] YMAX = AW'(IMG_H - WIN_H);

    logic [DW-1:0] mem [N];
    state_t        state;
    logic [2:0]    op;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [AW-1:0] ld_idx;
    logic [AW-1:0] addr;
    logic          last;
    logic          mirror;

    lcd_win_addr_gen #(
        .IMG_W (IMG_W),
        .WIN_W (WIN_W),
        .WIN_H (WIN_H),
        .AW    (AW)
    ) u_addr (
        .clk    (clk),
        .reset  (reset),
        .en     (state == S_OUT),
        .mirror (mirror),
        .x      (x),
        .y      (y),
        .addr   (addr),
        .last   (last)
    );

    // Pixel store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            mem[ld_idx] <= datain;
        end else if (state == S_EXEC && op == CMD_CLEAR) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end
    end

`ifndef LCD_WIN_MIRROR_EN
    assign mirror = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            op           <= CMD_REFLASH;
            x            <= X0;
            y            <= Y0;
            ld_idx       <= '0;
            dataout      <= '0;
            output_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef LCD_WIN_MIRROR_EN
            mirror       <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    output_valid <= 1'b0;
                    if (cmd_valid && !busy) begin
                        busy <= 1'b1;
                        op   <= cmd;
                        if (cmd == CMD_LOAD) begin
                            state  <= S_LOAD;
                            ld_idx <= '0;
                            x      <= X0;
                            y      <= Y0;
`ifdef LCD_WIN_MIRROR_EN
                            mirror <= 1'b0;
`endif
                        end else begin
                            state <= S_EXEC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    ld_idx <= ld_idx + 1'b1;
                    if (ld_idx == AW'(N - 1)) state <= S_OUT;
                end
                S_EXEC: begin
                    case (op)
                        CMD_RIGHT: if (x < XMAX) x <= x + 1'b1;
                        CMD_LEFT:  if (x != '0)  x <= x - 1'b1;
                        CMD_UP:    if (y != '0)  y <= y - 1'b1;
                        CMD_DOWN:  if (y < YMAX) y <= y + 1'b1;
`ifdef LCD_WIN_MIRROR_EN
                        CMD_MIRROR: mirror <= ~mirror;
`endif
                        default: ;
                    endcase
                    state <= S_OUT;
                end
                S_OUT: begin
                    output_valid <= 1'b1;
                    dataout      <= mem[addr];
                    if (last) state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Scoreboard bench for lcd_win_ctrl using directed windows.
// Mirror expectations follow LCD_WIN_MIRROR_EN.
module tb_lcd_win_ctrl;
    import lcd_win_pkg::*;

    typedef logic [7:0] win_t [9];

    localparam int N = 36;

    localparam win_t W_D  = '{14, 15, 16, 20, 21, 22, 26, 27, 28};
    localparam win_t W_R  = '{15, 16, 17, 21, 22, 23, 27, 28, 29};
    localparam win_t W_L1 = '{13, 14, 15, 19, 20, 21, 25, 26, 27};
    localparam win_t W_L0 = '{12, 13, 14, 18, 19, 20, 24, 25, 26};
    localparam win_t W_U1 = '{8, 9, 10, 14, 15, 16, 20, 21, 22};
    localparam win_t W_U0 = '{2, 3, 4, 8, 9, 10, 14, 15, 16};
    localparam win_t W_D3 = '{20, 21, 22, 26, 27, 28, 32, 33, 34};
    localparam win_t W_M3 = '{22, 21, 20, 28, 27, 26, 34, 33, 32};
    localparam win_t W_Z  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] datain;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] dataout;
    logic       output_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    lcd_win_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (output_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat: got %0d expected none", dataout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dataout !== e) begin
                    errors++;
                    $display("FAIL beat: got %0d expected %0d", dataout, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c);
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("accept_busy", int'(busy), 1);
        if (c == CMD_LOAD) begin
            for (int i = 0; i < N; i++) begin
                datain = 8'(i);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = output_valid;
        end
        if (!got) begin
            errors++;
            $display("FAIL timeout: got no output_valid expected beats");
        end
    endtask

    task automatic run_cmd(input logic [2:0] c, input win_t e,
                           input bit pulse);
        bit got;
        int n;
        foreach (e[k]) exp_q.push_back(e[k]);
        issue(c);
        wait_valid(got);
        n = 0;
        while (got && output_valid && n < 20) begin
            n++;
            if (pulse && n == 3) begin
                cmd       = CMD_RIGHT;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("beat_count", n, 9);
        chk("busy_drop", int'(busy), 0);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_mid(input win_t e);
        bit got;
        int n;
        foreach (e[k]) exp_q.push_back(e[k]);
        issue(CMD_REFLASH);
        wait_valid(got);
        n = 1;
        while (got && output_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        #2;
        reset = 1'b0;
        #1;
        chk("rst_valid", int'(output_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data", int'(dataout), 0);
        chk("rst_left", exp_q.size(), 5);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        cmd       = '0;
        cmd_valid = 1'b0;
        datain    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_valid", int'(output_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_data", int'(dataout), 0);

        run_cmd(CMD_LOAD, W_D, 1'b0);
        run_cmd(CMD_REFLASH, W_D, 1'b0);
        run_cmd(CMD_RIGHT, W_R, 1'b0);
        run_cmd(CMD_RIGHT, W_R, 1'b0);
        run_cmd(CMD_RIGHT, W_R, 1'b0);
        run_cmd(CMD_LEFT, W_D, 1'b0);
        run_cmd(CMD_LEFT, W_L1, 1'b0);
        run_cmd(CMD_LEFT, W_L0, 1'b0);
        run_cmd(CMD_LEFT, W_L0, 1'b0);

        run_cmd(CMD_LOAD, W_D, 1'b0);
        run_cmd(CMD_UP, W_U1, 1'b0);
        run_cmd(CMD_UP, W_U0, 1'b0);
        run_cmd(CMD_UP, W_U0, 1'b0);
        run_cmd(CMD_DOWN, W_U1, 1'b0);
        run_cmd(CMD_DOWN, W_D, 1'b0);
        run_cmd(CMD_DOWN, W_D3, 1'b0);
        run_cmd(CMD_DOWN, W_D3, 1'b0);

`ifdef LCD_WIN_MIRROR_EN
        run_cmd(CMD_MIRROR, W_M3, 1'b0);
        run_cmd(CMD_REFLASH, W_M3, 1'b0);
`else
        run_cmd(CMD_MIRROR, W_D3, 1'b0);
        run_cmd(CMD_REFLASH, W_D3, 1'b0);
`endif
        run_cmd(CMD_MIRROR, W_D3, 1'b0);

        run_cmd(CMD_REFLASH, W_D3, 1'b1);
        run_cmd(CMD_REFLASH, W_D3, 1'b0);

        reset_mid(W_D3);
        run_cmd(CMD_REFLASH, W_D, 1'b0);

        run_cmd(CMD_CLEAR, W_Z, 1'b0);
        run_cmd(CMD_UP, W_Z, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
